// File: rtl/pps_gated_counter_pkg.sv
// -----------------------------------------------------------------------------
// pps_gated_counter_pkg
// Shared definitions for the PPS-gated reference-clock counter:
//   - gate state encodings (HUNT / GATE)
//   - default measurement width and default PPS-lost timeout
//   - helper that sizes the idle (timeout) counter
// -----------------------------------------------------------------------------
package pps_gated_counter_pkg;

  // Gate state machine encodings.
  typedef enum logic {
    PGC_HUNT = 1'b0,  // waiting for a PPS edge to open a gate
    PGC_GATE = 1'b1   // gate open, counting clk cycles
  } pgc_state_e;

  // Default measurement / counter width.
  localparam int PGC_DEFAULT_WIDTH = 35;

  // Default number of clk cycles without a PPS edge before it is declared lost.
  localparam int PGC_DEFAULT_TIMEOUT = 2**26;

  // Bits needed for an idle counter that must hold TIMEOUT-1 without wrapping.
  function automatic int pgc_idle_bits(input int timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/pps_gated_counter_sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
// Synchronizes an asynchronous level into the clk domain and produces a
// registered one-cycle pulse on each rising edge. Reusable for PPS, encoder
// and button inputs.
//
// Latency: a rising edge on `in` shows up on `rise` STAGES+1 clk cycles later
// (STAGES synchronizer flops, then the registered edge compare against the
// history flop).
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset
//   in   in   raw asynchronous input
//   rise out  one-cycle pulse per synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int STAGES = 2   // synchronizer depth, must be >= 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_hist;
  logic              r_rise;
  logic              w_level;

  // Last synchronizer stage is the first metastability-safe copy.
  assign w_level = r_sync[STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], in};
      r_hist <= w_level;
      // The history flop forces a low between two detected edges, so the
      // pulse can never be wider than one cycle.
      r_rise <= w_level & ~r_hist;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/pps_gated_counter.sv
// -----------------------------------------------------------------------------
// pps_gated_counter
// Measures the reference clock against the GPS 1PPS. Counts clk cycles across
// a gate of (gate_seconds+1) consecutive PPS periods and latches each result
// into a holding register read through a valid/ack handshake. Also flags a
// lost PPS (no edge within TIMEOUT_CYCLES) and counter saturation.
//
// Handshake: `valid` rises the cycle after a gate closes and stays high until
// a cycle in which `ack` is sampled high; `ack` while `valid` is low is
// ignored. A new result arriving while `valid` is still high overwrites
// `measurement` and sets sticky `overrun`, unless `ack` is sampled on that
// same edge, in which case the new result is unread and `overrun` clears.
//
// Ports:
//   clk          in   counted reference clock, rising edge
//   rst          in   asynchronous active-high reset
//   pps_in       in   raw GPS pulse (asynchronous)
//   gate_seconds in   gate length minus one, in PPS periods (sampled at open)
//   measurement  out  last latched cycle count
//   valid        out  measurement is unread
//   ack          in   consumer read strobe
//   overrun      out  sticky: a result was overwritten while valid
//   saturated    out  current measurement is clipped at all-ones
//   pps_lost     out  no PPS edge within TIMEOUT_CYCLES
//   pps_strobe   out  one-cycle pulse per detected PPS rising edge
//   dbg_state    out  gate state (0 = HUNT, 1 = GATE)
// -----------------------------------------------------------------------------
module pps_gated_counter
  import pps_gated_counter_pkg::*;
#(
  parameter int WIDTH          = PGC_DEFAULT_WIDTH,
  parameter int GATE_BITS      = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = PGC_DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pps_in,
  input  logic [GATE_BITS-1:0] gate_seconds,
  output logic [WIDTH-1:0]     measurement,
  output logic                 valid,
  input  logic                 ack,
  output logic                 overrun,
  output logic                 saturated,
  output logic                 pps_lost,
  output logic                 pps_strobe,
  output logic                 dbg_state
);

  localparam int IDLE_BITS = pgc_idle_bits(TIMEOUT_CYCLES);
  // The idle counter trips when it is about to step onto TIMEOUT-1 and then
  // parks there until the next edge, so the flag is raised exactly once.
  localparam logic [IDLE_BITS-1:0] IDLE_TRIP = IDLE_BITS'(TIMEOUT_CYCLES - 2);
  localparam logic [IDLE_BITS-1:0] IDLE_MAX  = IDLE_BITS'(TIMEOUT_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Edge detection
  // ---------------------------------------------------------------------------
  logic w_rise;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .in   (pps_in),
    .rise (w_rise)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  pgc_state_e           r_state;
  pgc_state_e           w_state_next;
  logic [GATE_BITS-1:0] r_gate_len;
  logic [GATE_BITS-1:0] r_periods;
  logic [WIDTH-1:0]     r_counter;
  logic [IDLE_BITS-1:0] r_idle;
  logic [WIDTH-1:0]     r_meas;
  logic                 r_valid;
  logic                 r_overrun;
  logic                 r_saturated;
  logic                 r_lost;

  // Decoded per-cycle actions.
  logic w_open;      // start a new gate (from HUNT, or back-to-back on close)
  logic w_close;     // gate complete: latch result
  logic w_mid_edge;  // edge inside a multi-period gate
  logic w_timeout;   // idle counter about to reach TIMEOUT-1
  logic w_cnt_full;  // counter is at all-ones

  assign w_timeout  = !w_rise && (r_idle == IDLE_TRIP);
  assign w_cnt_full = &r_counter;

  // ---------------------------------------------------------------------------
  // Gate FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PGC_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate FSM: next state and action decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_open       = 1'b0;
    w_close      = 1'b0;
    w_mid_edge   = 1'b0;
    case (r_state)
      PGC_HUNT: begin
        if (w_rise) begin
          w_open       = 1'b1;
          w_state_next = PGC_GATE;
        end
      end
      PGC_GATE: begin
        if (w_rise) begin
          if (r_periods == r_gate_len) begin
            // Close and reopen on the same edge so no cycles are lost
            // between consecutive gates.
            w_close = 1'b1;
            w_open  = 1'b1;
          end else begin
            w_mid_edge = 1'b1;
          end
        end else if (w_timeout) begin
          // Partial gate is discarded; the held result is left alone.
          w_state_next = PGC_HUNT;
        end
      end
      default: begin
        w_state_next = PGC_HUNT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Gate datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gate_len <= '0;
      r_periods  <= '0;
      r_counter  <= '0;
    end else begin
      if (w_open) begin
        r_gate_len <= gate_seconds;
        r_periods  <= '0;
        // The open edge cycle itself is the first counted cycle, so the count
        // at the close edge equals the open-to-close distance in cycles.
        r_counter  <= WIDTH'(1);
      end else begin
        if (w_mid_edge) begin
          r_periods <= r_periods + GATE_BITS'(1);
        end
        if (w_state_next == PGC_GATE && !w_cnt_full) begin
          r_counter <= r_counter + WIDTH'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // PPS-lost watchdog
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
      r_lost <= 1'b0;
    end else begin
      if (w_rise) begin
        r_idle <= '0;
        r_lost <= 1'b0;
      end else begin
        if (r_idle != IDLE_MAX) begin
          r_idle <= r_idle + IDLE_BITS'(1);
        end
        if (w_timeout) begin
          r_lost <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result holding register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meas      <= '0;
      r_saturated <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_close) begin
        r_meas      <= r_counter;
        r_saturated <= w_cnt_full;
        r_valid     <= 1'b1;
        // A coincident ack consumes the old value, so the new one is not
        // an overrun; otherwise overwriting an unread value is.
        if (ack) begin
          r_overrun <= 1'b0;
        end else if (r_valid) begin
          r_overrun <= 1'b1;
        end
      end else if (ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign measurement = r_meas;
  assign valid       = r_valid;
  assign overrun     = r_overrun;
  assign saturated   = r_saturated;
  assign pps_lost    = r_lost;
  assign pps_strobe  = w_rise;
  assign dbg_state   = r_state;

endmodule
